dram_ar_arbiter: RTL and testbench

Round-robin arbiter that shares the single AXI read port of the `dram` model among `1<<SEL_WIDTH` read masters, for example several `prefetcherTop` instances or GPU banks.
- AR path: one registered output stage. The winner's index is appended above its transaction ID on the DRAM side.
- R path: each R beat is routed back to its requester by decoding those upper ID bits.
- Optional per-requester outstanding-burst limiter throttles any one requester from monopolising the DRAM queue.

---
 rtl/dram_ar_arbiter_if.sv | 52 +++++
 rtl/dram_ar_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_dram_ar_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_ar_arbiter_if.sv
// Bus bundle for dram_ar_arbiter: requester-side AR/R vectors and the DRAM-side AR/R channel.
//   slave  : arbiter view (consumes requester AR and DRAM R, drives DRAM AR and requester R).
//   master : environment view (requesters + DRAM model), the mirror of slave.
// Vector signal x carries requester i's slice at index/offset i.
interface dram_ar_arbiter_if #(
  parameter int unsigned SEL_WIDTH       = 1,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned DATA_WIDTH      = 256
);
  localparam int unsigned NumReq = 1 << SEL_WIDTH;

  // Requester-side AR
  logic [NumReq-1:0]                 s_ar_valid;
  logic [NumReq-1:0]                 s_ar_ready;
  logic [NumReq*ADDR_WIDTH-1:0]      s_ar_addr;
  logic [NumReq*BURST_LEN_WIDTH-1:0] s_ar_len;
  logic [NumReq*ID_WIDTH-1:0]        s_ar_id;
  // DRAM-side AR
  logic                              m_ar_valid;
  logic                              m_ar_ready;
  logic [ADDR_WIDTH-1:0]             m_ar_addr;
  logic [BURST_LEN_WIDTH-1:0]        m_ar_len;
  logic [ID_WIDTH+SEL_WIDTH-1:0]     m_ar_id;
  // DRAM-side R
  logic                              m_r_valid;
  logic                              m_r_ready;
  logic                              m_r_last;
  logic [DATA_WIDTH-1:0]             m_r_data;
  logic [ID_WIDTH+SEL_WIDTH-1:0]     m_r_id;
  // Requester-side R
  logic [NumReq-1:0]                 s_r_valid;
  logic [NumReq-1:0]                 s_r_ready;
  logic                              s_r_last;
  logic [DATA_WIDTH-1:0]             s_r_data;
  logic [ID_WIDTH-1:0]               s_r_id;

  modport slave (
    input  s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, m_ar_ready,
    input  m_r_valid, m_r_last, m_r_data, m_r_id, s_r_ready,
    output s_ar_ready, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    output m_r_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );

  modport master (
    output s_ar_valid, s_ar_addr, s_ar_len, s_ar_id, m_ar_ready,
    output m_r_valid, m_r_last, m_r_data, m_r_id, s_r_ready,
    input  s_ar_ready, m_ar_valid, m_ar_addr, m_ar_len, m_ar_id,
    input  m_r_ready, s_r_valid, s_r_last, s_r_data, s_r_id
  );
endinterface

// File: rtl/dram_ar_arbiter.sv
// Round-robin arbiter sharing one DRAM AXI read port among 1<<SEL_WIDTH read masters.
//   AR: one registered output stage; the winner index is prepended to its ID on the DRAM side.
//   R : beats are routed back combinationally by decoding the upper ID bits.
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   bus (slave)       - requester AR/R vectors and DRAM AR/R channel
//   crs_outstandLimit - max outstanding bursts per requester (0 = unlimited)
//   err_underflow     - sticky: R last seen for a requester with no outstanding burst
// Optional feature: define ARB_OUTSTAND_LIMIT_EN to build the per-requester outstanding-burst
// limiter. Without it, crs_outstandLimit is ignored and err_underflow is tied low.
module dram_ar_arbiter #(
  parameter int unsigned SEL_WIDTH       = 1,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned DATA_WIDTH      = 256,
  parameter int unsigned OUTSTAND_WIDTH  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  dram_ar_arbiter_if.slave          bus,
  input  logic [OUTSTAND_WIDTH-1:0] crs_outstandLimit,
  output logic                      err_underflow
);
  localparam int unsigned NumReq  = 1 << SEL_WIDTH;
  localparam int unsigned MidWidth = ID_WIDTH + SEL_WIDTH;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                     state_q, state_d;
  logic [SEL_WIDTH-1:0]       ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [MidWidth-1:0]        id_q, id_d;

  logic [NumReq-1:0]    allow;
  logic [NumReq-1:0]    eligible;
  logic                 acc;
  logic                 found;
  logic                 grant;
  logic [SEL_WIDTH-1:0] winner;
  logic [SEL_WIDTH-1:0] idx;
  logic [SEL_WIDTH-1:0] r_sel;

  // ---------------------------------------------------------------------------------------------
  // R routing: purely combinational, independent of the AR FSM
  // ---------------------------------------------------------------------------------------------
  assign r_sel = bus.m_r_id[MidWidth-1:ID_WIDTH];

  always_comb begin
    bus.s_r_valid        = '0;
    bus.s_r_valid[r_sel] = bus.m_r_valid;
    bus.m_r_ready        = bus.s_r_ready[r_sel];
    bus.s_r_last         = bus.m_r_last;
    bus.s_r_data         = bus.m_r_data;
    bus.s_r_id           = bus.m_r_id[ID_WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------------------------
  // Arbitration: first eligible requester searching upward from ptr, wrapping at NumReq
  // ---------------------------------------------------------------------------------------------
  assign eligible = bus.s_ar_valid & allow;
  assign acc      = (state_q == StIdle) || bus.m_ar_ready;
  // Gating by rst keeps s_ar_ready low and the counters untouched while in reset.
  assign grant    = acc && found && !rst;

  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = ptr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = ptr_q + SEL_WIDTH'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    bus.s_ar_ready = '0;
    if (grant) bus.s_ar_ready[winner] = 1'b1;
  end

  // ---------------------------------------------------------------------------------------------
  // AR FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    // Without acc the output stage is stalled and everything holds (AXI valid-stable).
    if (acc) begin
      if (found) begin
        state_d = StBusy;
        ptr_d   = winner + SEL_WIDTH'(1);
        addr_d  = bus.s_ar_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        len_d   = bus.s_ar_len[winner*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        id_d    = {winner, bus.s_ar_id[winner*ID_WIDTH +: ID_WIDTH]};
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    bus.m_ar_valid = (state_q == StBusy);
    bus.m_ar_addr  = addr_q;
    bus.m_ar_len   = len_q;
    bus.m_ar_id    = id_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Outstanding-burst limiter
  // ---------------------------------------------------------------------------------------------
`ifdef ARB_OUTSTAND_LIMIT_EN
  logic [OUTSTAND_WIDTH-1:0] cnt_q [NumReq];
  logic [OUTSTAND_WIDTH-1:0] cnt_d [NumReq];
  logic [NumReq-1:0]         inc;
  logic [NumReq-1:0]         dec;
  logic                      r_done;
  logic                      err_q, err_d;

  assign r_done = bus.m_r_valid && bus.m_r_ready && bus.m_r_last;

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      allow[i] = (cnt_q[i] != '1) &&
                 ((crs_outstandLimit == '0) || (cnt_q[i] < crs_outstandLimit));
      inc[i]   = grant && (winner == SEL_WIDTH'(i));
      dec[i]   = r_done && (r_sel == SEL_WIDTH'(i));
    end
  end

  always_comb begin
    err_d = err_q;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + OUTSTAND_WIDTH'(1);
      end else if (dec[i] && !inc[i]) begin
        // A return with nothing outstanding is a protocol error; hold the count at 0.
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - OUTSTAND_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NumReq; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_underflow = err_q;
`else
  logic unused_limit;

  assign allow         = '1;
  assign err_underflow = 1'b0;
  assign unused_limit  = ^crs_outstandLimit;
`endif

endmodule

// File: tb/tb_dram_ar_arbiter.sv
module tb_dram_ar_arbiter;
  localparam int SW = 1;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int LW = 8;
  localparam int DW = 256;
  localparam int OW = 5;
  localparam int N  = 1 << SW;
  localparam int MW = IW + SW;
`ifdef ARB_OUTSTAND_LIMIT_EN
  localparam bit LimEn = 1'b1;
`else
  localparam bit LimEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] limit;
  logic          err;

  always #5 clk = ~clk;

  dram_ar_arbiter_if #(
    .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN_WIDTH(LW), .DATA_WIDTH(DW)
  ) bus ();

  dram_ar_arbiter #(
    .SEL_WIDTH(SW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .BURST_LEN_WIDTH(LW), .DATA_WIDTH(DW),
    .OUTSTAND_WIDTH(OW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .crs_outstandLimit(limit),
    .err_underflow    (err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one outstanding output slot, a rotating priority start, per-requester counts.
  int          m_ptr;
  bit          m_busy;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [MW-1:0] m_id;
  int          m_cnt[N];
  bit          m_err;

  function automatic bit model_allowed(input int i);
    if (!LimEn) return 1'b1;
    if (m_cnt[i] >= (1 << OW) - 1) return 1'b0;
    if (limit != 0 && m_cnt[i] >= int'(limit)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_winner();
    int i;
    if (rst) return -1;
    if (m_busy && !bus.m_ar_ready) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (bus.s_ar_valid[i] && model_allowed(i)) return i;
    end
    return -1;
  endfunction

  function automatic int model_rsel();
    return int'(bus.m_r_id) >> IW;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = model_winner();
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  // Advance one clock and the model alongside it; returns at posedge + 1.
  task automatic tick();
    int w, rs;
    bit rdone, r_rst, acc;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [IW-1:0] id;
    w     = model_winner();
    rs    = model_rsel();
    rdone = bus.m_r_valid && bus.s_r_ready[rs] && bus.m_r_last;
    r_rst = rst;
    acc   = !m_busy || bus.m_ar_ready;
    a = '0; l = '0; id = '0;
    if (w >= 0) begin
      a  = bus.s_ar_addr[w*AW +: AW];
      l  = bus.s_ar_len[w*LW +: LW];
      id = bus.s_ar_id[w*IW +: IW];
    end
    @(posedge clk);
    if (r_rst) begin
      m_ptr = 0; m_busy = 0; m_addr = '0; m_len = '0; m_id = '0; m_err = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (acc) begin
        if (w >= 0) begin
          m_busy = 1; m_addr = a; m_len = l; m_id = {SW'(w), id}; m_ptr = (w + 1) % N;
        end else begin
          m_busy = 0;
        end
      end
      if (LimEn) begin
        for (int i = 0; i < N; i++) begin
          if (w == i && !(rdone && rs == i)) m_cnt[i]++;
          else if (rdone && rs == i && w != i) begin
            if (m_cnt[i] == 0) m_err = 1;
            else m_cnt[i]--;
          end
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_ar_valid = '0;
    bus.s_ar_addr  = '0;
    bus.s_ar_len   = '0;
    bus.s_ar_id    = '0;
    bus.m_ar_ready = 1'b1;
    bus.m_r_valid  = 1'b0;
    bus.m_r_last   = 1'b0;
    bus.m_r_data   = '0;
    bus.m_r_id     = '0;
    bus.s_r_ready  = '0;
    limit          = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.s_ar_valid = '1;
    #1;
    n_chk++; if (bus.s_ar_ready !== '0) $display("FAIL reset_ready got %b exp 0", bus.s_ar_ready); else n_pass++;
    tick();
    tick();
    n_chk++; if (bus.s_ar_ready !== '0) $display("FAIL reset_ready2 got %b exp 0", bus.s_ar_ready); else n_pass++;
    n_chk++; if (bus.m_ar_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.m_ar_valid); else n_pass++;
    n_chk++; if (bus.m_ar_addr !== '0) $display("FAIL reset_addr got %h exp 0", bus.m_ar_addr); else n_pass++;
    n_chk++; if (bus.m_ar_len !== '0) $display("FAIL reset_len got %h exp 0", bus.m_ar_len); else n_pass++;
    n_chk++; if (bus.m_ar_id !== '0) $display("FAIL reset_id got %h exp 0", bus.m_ar_id); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
    rst = 1'b0;
    bus.s_ar_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    bus.s_ar_valid = '1;
    bus.m_ar_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.s_ar_addr[i*AW +: AW] = AW'(16'h0100 * (i + 1));
      bus.s_ar_id[i*IW +: IW]   = IW'(8'h30 + i);
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      exp = N'(1) << (k % 2);
      n_chk++; if (bus.s_ar_ready !== exp) $display("FAIL rr_ready[%0d] got %b exp %b", k, bus.s_ar_ready, exp); else n_pass++;
      tick();
      n_chk++; if (bus.m_ar_valid !== 1'b1) $display("FAIL rr_valid[%0d] got %b exp 1", k, bus.m_ar_valid); else n_pass++;
      n_chk++; if (int'(bus.m_ar_id[MW-1:IW]) !== k % 2) $display("FAIL rr_sel[%0d] got %0d exp %0d", k, bus.m_ar_id[MW-1:IW], k % 2); else n_pass++;
      n_chk++; if (bus.m_ar_addr !== AW'(16'h0100 * (k % 2 + 1))) $display("FAIL rr_addr[%0d] got %h exp %h", k, bus.m_ar_addr, 16'h0100 * (k % 2 + 1)); else n_pass++;
    end
    bus.s_ar_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.s_ar_valid = 2'b01;
    bus.s_ar_addr  = {16'h5500, 16'h1000};
    bus.s_ar_len   = {8'h07, 8'h03};
    bus.s_ar_id    = {8'h22, 8'h11};
    #1;
    n_chk++; if (bus.s_ar_ready !== 2'b01) $display("FAIL bp_first_ready got %b exp 01", bus.s_ar_ready); else n_pass++;
    tick();
    bus.m_ar_ready = 1'b0;
    bus.s_ar_valid = 2'b11;
    bus.s_ar_addr  = {16'h5500, 16'h2000};
    for (int k = 0; k < 5; k++) begin
      #1;
      n_chk++; if (bus.s_ar_ready !== 2'b00) $display("FAIL bp_ready[%0d] got %b exp 00", k, bus.s_ar_ready); else n_pass++;
      n_chk++; if (bus.m_ar_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", k, bus.m_ar_valid); else n_pass++;
      n_chk++; if (bus.m_ar_addr !== 16'h1000) $display("FAIL bp_addr[%0d] got %h exp 1000", k, bus.m_ar_addr); else n_pass++;
      n_chk++; if (bus.m_ar_len !== 8'h03) $display("FAIL bp_len[%0d] got %h exp 03", k, bus.m_ar_len); else n_pass++;
      n_chk++; if (bus.m_ar_id !== 9'h011) $display("FAIL bp_id[%0d] got %h exp 011", k, bus.m_ar_id); else n_pass++;
      tick();
    end
    bus.m_ar_ready = 1'b1;
    #1;
    n_chk++; if (bus.s_ar_ready !== 2'b10) $display("FAIL bp_resume_ready got %b exp 10", bus.s_ar_ready); else n_pass++;
    tick();
    n_chk++; if (bus.m_ar_id !== 9'h122) $display("FAIL bp_resume_id got %h exp 122", bus.m_ar_id); else n_pass++;
    n_chk++; if (bus.m_ar_addr !== 16'h5500) $display("FAIL bp_resume_addr got %h exp 5500", bus.m_ar_addr); else n_pass++;
    bus.s_ar_valid = '0;
    tick();
  endtask

  task automatic test_r_routing();
    logic [DW-1:0] d;
    for (int b = 0; b < DW / 32; b++) d[b*32 +: 32] = $urandom;
    bus.m_r_valid = 1'b1;
    bus.m_r_last  = 1'b1;
    bus.m_r_id    = 9'h105;
    bus.m_r_data  = d;
    bus.s_r_ready = 2'b10;
    #1;
    n_chk++; if (bus.s_r_valid !== 2'b10) $display("FAIL rr_route_valid got %b exp 10", bus.s_r_valid); else n_pass++;
    n_chk++; if (bus.s_r_id !== 8'h05) $display("FAIL r_route_id got %h exp 05", bus.s_r_id); else n_pass++;
    n_chk++; if (bus.m_r_ready !== 1'b1) $display("FAIL r_route_ready1 got %b exp 1", bus.m_r_ready); else n_pass++;
    n_chk++; if (bus.s_r_last !== 1'b1) $display("FAIL r_route_last got %b exp 1", bus.s_r_last); else n_pass++;
    n_chk++; if (bus.s_r_data !== d) $display("FAIL r_route_data got %h exp %h", bus.s_r_data, d); else n_pass++;
    bus.s_r_ready = 2'b01;
    #1;
    n_chk++; if (bus.m_r_ready !== 1'b0) $display("FAIL r_route_ready0 got %b exp 0", bus.m_r_ready); else n_pass++;
    bus.m_r_id = 9'h0a7;
    #1;
    n_chk++; if (bus.s_r_valid !== 2'b01) $display("FAIL r_route_valid0 got %b exp 01", bus.s_r_valid); else n_pass++;
    n_chk++; if (bus.m_r_ready !== 1'b1) $display("FAIL r_route_ready_sel0 got %b exp 1", bus.m_r_ready); else n_pass++;
    bus.m_r_valid = 1'b0;
    bus.s_r_ready = '0;
    #1;
    n_chk++; if (bus.s_r_valid !== 2'b00) $display("FAIL r_route_novalid got %b exp 00", bus.s_r_valid); else n_pass++;
  endtask

`ifdef ARB_OUTSTAND_LIMIT_EN
  task automatic test_limiter();
    logic [N-1:0] seq_valid [6] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b01};
    logic [N-1:0] seq_ready [6] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
    idle_inputs();
    do_reset();
    limit = 5'd2;
    for (int k = 0; k < 6; k++) begin
      bus.s_ar_valid = seq_valid[k];
      // Cycle 4 returns one burst for requester 0; the freed slot is usable the next cycle.
      bus.m_r_valid  = (k == 4);
      bus.m_r_last   = 1'b1;
      bus.m_r_id     = 9'h000;
      bus.s_r_ready  = 2'b01;
      #1;
      n_chk++; if (bus.s_ar_ready !== seq_ready[k]) $display("FAIL lim_ready[%0d] got %b exp %b", k, bus.s_ar_ready, seq_ready[k]); else n_pass++;
      tick();
    end
    n_chk++; if (bus.m_ar_id[MW-1:IW] !== 1'b0) $display("FAIL lim_last_sel got %b exp 0", bus.m_ar_id[MW-1:IW]); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL lim_err got %b exp 0", err); else n_pass++;
    idle_inputs();
    tick();
  endtask
`endif

  task automatic test_underflow();
    idle_inputs();
    do_reset();
    bus.m_r_valid = 1'b1;
    bus.m_r_last  = 1'b1;
    bus.m_r_id    = 9'h122;
    bus.s_r_ready = 2'b10;
    #1;
    n_chk++; if (err !== 1'b0) $display("FAIL uf_before got %b exp 0", err); else n_pass++;
    tick();
    bus.m_r_valid = 1'b0;
    n_chk++; if (err !== LimEn) $display("FAIL uf_set got %b exp %b", err, LimEn); else n_pass++;
    bus.s_ar_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (err !== LimEn) $display("FAIL uf_sticky[%0d] got %b exp %b", k, err, LimEn); else n_pass++;
    end
    idle_inputs();
    do_reset();
    n_chk++; if (err !== 1'b0) $display("FAIL uf_cleared got %b exp 0", err); else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    int rs;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.s_ar_valid = N'($urandom);
      bus.m_ar_ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        bus.s_ar_addr[i*AW +: AW] = AW'($urandom);
        bus.s_ar_len[i*LW +: LW]  = LW'($urandom);
        bus.s_ar_id[i*IW +: IW]   = IW'($urandom);
      end
      if ($urandom % 16 == 0) limit = OW'($urandom % 4);
      bus.m_r_valid = $urandom % 2;
      bus.m_r_last  = $urandom % 2;
      bus.m_r_id    = MW'($urandom);
      bus.m_r_data  = {8{$urandom}};
      bus.s_r_ready = N'($urandom);
      #1;
      er = exp_ready();
      rs = model_rsel();
      n_chk++; if (bus.s_ar_ready !== er) $display("FAIL rnd_ready[%0d] got %b exp %b", c, bus.s_ar_ready, er); else n_pass++;
      n_chk++; if (bus.m_r_ready !== bus.s_r_ready[rs]) $display("FAIL rnd_mrready[%0d] got %b exp %b", c, bus.m_r_ready, bus.s_r_ready[rs]); else n_pass++;
      n_chk++; if (bus.s_r_valid !== (N'(bus.m_r_valid) << rs)) $display("FAIL rnd_srvalid[%0d] got %b sel %0d", c, bus.s_r_valid, rs); else n_pass++;
      n_chk++; if (bus.s_r_id !== bus.m_r_id[IW-1:0]) $display("FAIL rnd_srid[%0d] got %h exp %h", c, bus.s_r_id, bus.m_r_id[IW-1:0]); else n_pass++;
      tick();
      n_chk++; if (bus.m_ar_valid !== m_busy) $display("FAIL rnd_valid[%0d] got %b exp %b", c, bus.m_ar_valid, m_busy); else n_pass++;
      if (m_busy) begin
        n_chk++; if ({bus.m_ar_id, bus.m_ar_len, bus.m_ar_addr} !== {m_id, m_len, m_addr}) $display("FAIL rnd_ar[%0d] got %h/%h/%h exp %h/%h/%h", c, bus.m_ar_id, bus.m_ar_len, bus.m_ar_addr, m_id, m_len, m_addr); else n_pass++;
      end
      n_chk++; if (err !== m_err) $display("FAIL rnd_err[%0d] got %b exp %b", c, err, m_err); else n_pass++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    idle_inputs();
    bus.m_ar_ready = 1'b0;
    bus.s_ar_valid = 2'b10;
    tick();
    n_chk++; if (bus.m_ar_valid !== 1'b1) $display("FAIL rmb_busy got %b exp 1", bus.m_ar_valid); else n_pass++;
    rst = 1'b1;
    tick();
    n_chk++; if (bus.m_ar_valid !== 1'b0) $display("FAIL rmb_dropped got %b exp 0", bus.m_ar_valid); else n_pass++;
    rst = 1'b0;
    bus.s_ar_valid = 2'b11;
    bus.m_ar_ready = 1'b1;
    #1;
    n_chk++; if (bus.s_ar_ready !== 2'b01) $display("FAIL rmb_first_ready got %b exp 01", bus.s_ar_ready); else n_pass++;
    tick();
    n_chk++; if (bus.m_ar_id[MW-1:IW] !== 1'b0) $display("FAIL rmb_first_sel got %b exp 0", bus.m_ar_id[MW-1:IW]); else n_pass++;
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_r_routing();
`ifdef ARB_OUTSTAND_LIMIT_EN
    test_limiter();
`endif
    test_underflow();
    test_random();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
